uart_rx: RTL
============

# uart_rx

Serial receiver that pairs with the UART transmitter. It samples the asynchronous `rx` line and recovers 8N1 frames: one start bit, 8 data bits LSB first, one stop bit. It presents each byte with a one-cycle `valid` strobe and flags stop-bit errors with `frame_err`. It sits between the board RX pin and the byte-consuming logic (loopback, command decoder), using the same `CLK_PER_BAUD` as the transmitter.

## Interface
- `CLK_PER_BAUD`, default 16: clock cycles per bit. Legal range is ≥ 4.
- `HALF` (localparam) = `CLK_PER_BAUD`/2, floor.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `rx`  in  1: asynchronous serial line; idle high.
- `rx_byte`  out  8: last correctly framed byte; held until the next `valid`.
- `valid`  out  1: one-cycle pulse when `rx_byte` is updated.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1: high whenever state ≠ IDLE.

## Operation
- **Synchronizer.** Two flops, both reset to 1. `rx_s` is the second stage. All decisions use `rx_s` only.
- **Counters.**
  - `clk_cnt` runs 0..`CLK_PER_BAUD`-1. It is cleared on every state change and held at 0 in IDLE.
  - `bit_cnt` runs 0..7.
- **IDLE**
  - `rx_s`=0 → START.
- **START** (wait `HALF` cycles)
  - When `clk_cnt`=`HALF`-1: `rx_s`=0 → DATA. `rx_s`=1 means a glitch → IDLE, with no pulse.
- **DATA**
  - When `clk_cnt`=`CLK_PER_BAUD`-1: shift right with `shreg` = {`rx_s`, `shreg`[7:1]} and increment `bit_cnt`.
  - After the 8th sample → STOP, with `bit_cnt` cleared.
- **STOP**
  - When `clk_cnt`=`CLK_PER_BAUD`-1:
    - `rx_s`=1: load `rx_byte` ← `shreg`, pulse `valid`, go to IDLE.
    - `rx_s`=0: pulse `frame_err`, leave `rx_byte` unchanged, go to RECOVER.
- **RECOVER**
  - Wait for `rx_s`=1, then → IDLE.
  - A line held low (break) therefore yields exactly one `frame_err` and no further frames.
- **Simultaneous events.** A new start edge arriving in the cycle the stop bit is accepted is seen from IDLE on the next edge; back-to-back frames need no idle gap.
- **Reset** (any time, including mid-frame):
  - state = IDLE; `clk_cnt`, `bit_cnt`, `shreg`, `rx_byte` = 0.
  - `valid` = `frame_err` = 0; `busy` = 0; synchronizer flops = 1.
  - No pulse is generated for the aborted frame.

## Timing
- `valid`, `frame_err` and `rx_byte` are registered. `busy` is a decode of the state register.
- Edge 0 is the edge at which synchronizer stage 1 first captures `rx`=0. Then:
  - Edge 2: IDLE→START.
  - Edge 2+`HALF`: START→DATA (start bit confirmed).
  - Edge 2+`HALF`+(i+1)·`CLK_PER_BAUD`: data bit i sampled, for i = 0..7.
  - Edge 2+`HALF`+9·`CLK_PER_BAUD`: stop bit sampled. `valid` or `frame_err` is high for exactly the following cycle.
- With `CLK_PER_BAUD`=16 the stop bit is sampled at edge 154.
- Frame period is 10·`CLK_PER_BAUD`. The receiver sustains the full line rate.
- No backpressure. The consumer must take `rx_byte` within 10·`CLK_PER_BAUD` cycles of `valid`, or the byte is overwritten.

## Structure
- Shared package `uart_pkg`:
  - State enum `RxState_t`, 3 bits: IDLE=0, START=1, DATA=2, STOP=3, RECOVER=4.
  - `DATA_BITS`=8.
  - The transmitter's state type moves here too.
- Sub-module `sync_2ff`:
  - Generic two-flop synchronizer with parameter `RESET_VAL`, default 1.
  - Reusable for buttons and other pins.
- Next-state and datapath logic is combinational; registers live in a single clocked process.

## Test plan
All scenarios use `CLK_PER_BAUD`=16.
1. **Reset.** Hold `rst`=1 for 3 cycles with `rx`=0 → `rx_byte`=0x00, `valid`=0, `frame_err`=0, `busy`=0 throughout. After release with `rx` high, no pulses for 200 cycles.
2. **Single frame.** Send 0xA5 with stop bit 1 → `valid` high for one cycle after edge 154, `rx_byte`=0xA5, `busy` low the same cycle.
3. **Back-to-back frames.** Send 0x00 then 0xFF with no idle gap → two `valid` pulses 160 cycles apart; `rx_byte`=0x00, then 0xFF.
4. **Start glitch.** Drive `rx` low for 4 cycles (< `HALF`) → back in IDLE by edge 2+`HALF`; no `valid`, no `frame_err`.
5. **Framing error and recovery.** Send 0x3C, then hold the line low for 3 bit times → one `frame_err` pulse, no `valid`, `rx_byte` keeps its previous value, `busy` stays high until `rx` returns high. A following 0x55 frame gives `valid` with `rx_byte`=0x55.
6. **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 3 → no pulse; the next 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the receiver and transmitter
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      RECOVER = 3'd4
   } RxState_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } TxState_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous single-bit inputs
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with valid strobe and stop-bit error flag
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_PER_BAUD = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_byte,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int HALF = CLK_PER_BAUD / 2;
   localparam int CW   = $clog2(CLK_PER_BAUD);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BAUD - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

   logic                 rx_s;
   RxState_t             state, state_n;
   logic [CW-1:0]        clk_cnt, clk_cnt_n;
   logic [2:0]           bit_cnt, bit_cnt_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [DATA_BITS-1:0] rx_byte_n;
   logic                 valid_n, frame_err_n;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   always_comb begin
      state_n     = state;
      clk_cnt_n   = clk_cnt + 1'b1;
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      rx_byte_n   = rx_byte;
      valid_n     = 1'b0;
      frame_err_n = 1'b0;

      case (state)
         IDLE: begin
            clk_cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            // Mid-start-bit check rejects glitches shorter than half a bit
            if (clk_cnt == HALF_LAST) state_n = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (clk_cnt == CNT_LAST) begin
               clk_cnt_n = '0;
               shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt_n = '0;
                  state_n   = STOP;
               end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (clk_cnt == CNT_LAST) begin
               if (rx_s) begin
                  rx_byte_n = shreg;
                  valid_n   = 1'b1;
                  state_n   = IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = RECOVER;
               end
            end
         end
         RECOVER: begin
            clk_cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: begin
            clk_cnt_n = '0;
            state_n   = IDLE;
         end
      endcase

      if (state_n != state) clk_cnt_n = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_byte   <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         clk_cnt   <= clk_cnt_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         rx_byte   <= rx_byte_n;
         valid     <= valid_n;
         frame_err <= frame_err_n;
      end
   end

   assign busy = (state != IDLE);

endmodule
